// File: rtl/psum_sfu_ctrl.sv
// psum_sfu_ctrl: sequences partial-sum reads into a column of SFU lanes and
// writes the post-ReLU results to the output memory.
//
// For every output pixel o (0..num_out-1) the controller reads num_k psum rows
// (one per kernel position k) at address k*num_out+o. It holds the SFU in
// accumulate mode while that data arrives, spends one flush cycle so the SFU
// latches ReLU(sum) and clears, and then writes the lane results to address o.
// Each output takes num_k+3 cycles. A one-cycle done pulse ends the run.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   start        begins a run when sampled in IDLE, ignored otherwise
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of a run
//   psum_ren     psum memory read enable
//   psum_addr    psum memory read address (k*num_out+o), 0 when not reading
//   psum_q       psum memory read data, valid the cycle after psum_ren
//   sfu_acc      accumulate enable to the SFU lanes
//   sfu_psum     psum_q forwarded to the SFU lanes unchanged
//   sfu_out      post-ReLU SFU results
//   out_wen      output memory write enable
//   out_addr     output memory write address (o), 0 when not writing
//   out_d        output memory write data (sfu_out), 0 when not writing
module psum_sfu_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned num_k   = 9,
  parameter int unsigned num_out = 16,
  parameter int unsigned addr_bw = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     psum_ren,
  output logic [addr_bw-1:0]       psum_addr,
  input  logic [col*psum_bw-1:0]   psum_q,
  output logic                     sfu_acc,
  output logic [col*psum_bw-1:0]   sfu_psum,
  input  logic [col*psum_bw-1:0]   sfu_out,
  output logic                     out_wen,
  output logic [addr_bw-1:0]       out_addr,
  output logic [col*psum_bw-1:0]   out_d
);

  localparam int unsigned DATA_W = col * psum_bw;
  localparam int unsigned K_W    = (num_k > 1) ? $clog2(num_k) : 1;
  localparam int unsigned O_W    = (num_out > 1) ? $clog2(num_out) : 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(num_k - 1);
  localparam logic [O_W-1:0] O_LAST = O_W'(num_out - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] TAIL  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [K_W-1:0]     k;
  logic [K_W-1:0]     k_n;
  logic [O_W-1:0]     o;
  logic [O_W-1:0]     o_n;
  logic [addr_bw-1:0] rd_addr_n;

  // State and counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      o     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      o     <= o_n;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_n = state;
    k_n     = k;
    o_n     = o;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          k_n     = '0;
          o_n     = '0;
        end
      end
      READ: begin
        if (k == K_LAST) begin
          k_n     = '0;
          state_n = TAIL;
        end else begin
          k_n = k + K_W'(1);
        end
      end
      TAIL:  state_n = FLUSH;
      FLUSH: state_n = WRITE;
      WRITE: begin
        if (o == O_LAST) begin
          state_n = DONE;
        end else begin
          o_n     = o + O_W'(1);
          state_n = READ;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read address for the upcoming cycle, kept addr_bw wide
  always_comb begin
    rd_addr_n = addr_bw'(k_n) * addr_bw'(num_out) + addr_bw'(o_n);
  end

  // Outputs are registered from the next state so they line up with the state
  // they belong to; sfu_acc lags READ by one cycle to match memory latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      psum_ren  <= 1'b0;
      psum_addr <= '0;
      out_wen   <= 1'b0;
      out_addr  <= '0;
      sfu_acc   <= 1'b0;
    end else begin
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      psum_ren  <= (state_n == READ);
      psum_addr <= (state_n == READ) ? rd_addr_n : '0;
      out_wen   <= (state_n == WRITE);
      out_addr  <= (state_n == WRITE) ? addr_bw'(o_n) : '0;
      sfu_acc   <= (state == READ);
    end
  end

  // SFU result only becomes valid in WRITE (latched during FLUSH), so the
  // write data is forwarded directly rather than registered.
  assign out_d    = (state == WRITE) ? sfu_out : DATA_W'(0);
  assign sfu_psum = psum_q;

endmodule

// File: tb/tb_psum_sfu_ctrl.sv
// Bench for psum_sfu_ctrl: psum memory and behavioural SFU models around the
// DUT, stimulus pushes expected reads/writes/done times into queues, and a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_psum_sfu_ctrl;

  localparam int unsigned COL  = 8;
  localparam int unsigned PBW  = 16;
  localparam int unsigned NK   = 9;
  localparam int unsigned NOUT = 16;
  localparam int unsigned ABW  = 8;
  localparam int unsigned DW   = COL * PBW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          psum_ren;
  logic [ABW-1:0] psum_addr;
  logic [DW-1:0] psum_q;
  logic          sfu_acc;
  logic [DW-1:0] sfu_psum;
  logic [DW-1:0] sfu_out;
  logic          out_wen;
  logic [ABW-1:0] out_addr;
  logic [DW-1:0] out_d;

  psum_sfu_ctrl #(
    .col(COL), .psum_bw(PBW), .num_k(NK), .num_out(NOUT), .addr_bw(ABW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .psum_ren(psum_ren), .psum_addr(psum_addr), .psum_q(psum_q),
    .sfu_acc(sfu_acc), .sfu_psum(sfu_psum), .sfu_out(sfu_out),
    .out_wen(out_wen), .out_addr(out_addr), .out_d(out_d)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  mem [NK*NOUT];
  logic [ABW-1:0] exp_raddr [$];
  logic [ABW-1:0] exp_waddr [$];
  logic [DW-1:0]  exp_wdata [$];
  int             exp_done  [$];

  // Psum memory: registered read, data holds when not reading
  always @(posedge clk) begin
    if (reset) psum_q <= '0;
    else if (psum_ren) psum_q <= mem[int'(psum_addr)];
  end

  // Behavioural SFU: wrapping 16-bit accumulate, ReLU latch-and-clear when idle
  logic signed [PBW-1:0] sacc [COL];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COL; i++) sacc[i] <= '0;
      sfu_out <= '0;
    end else begin
      for (int i = 0; i < COL; i++) begin
        if (sfu_acc) begin
          sacc[i] <= sacc[i] + $signed(sfu_psum[i*PBW +: PBW]);
        end else begin
          sfu_out[i*PBW +: PBW] <= sacc[i][PBW-1] ? 16'h0000 : sacc[i];
          sacc[i] <= '0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] rest);
    logic [DW-1:0] v;
    v = {COL{rest}};
    v[15:0]  = l0;
    v[31:16] = l1;
    return v;
  endfunction

  // Monitor: compares every read, write and done pulse against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (psum_ren) begin
        if (exp_raddr.size() == 0) check("unexpected_read", 1, 0);
        else check("psum_addr", DW'(psum_addr), DW'(exp_raddr.pop_front()));
      end else begin
        check("psum_addr_idle_zero", DW'(psum_addr), 0);
      end
      if (out_wen) begin
        if (exp_waddr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          check("out_addr", DW'(out_addr), DW'(exp_waddr.pop_front()));
          check("out_d", out_d, exp_wdata.pop_front());
        end
      end else begin
        check("out_addr_idle_zero", DW'(out_addr), 0);
        check("out_d_idle_zero", out_d, 0);
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", DW'(cyc), DW'(exp_done.pop_front()));
      end
    end
  end

  // mode 0: all lanes +1; mode 1: lane0 -5, lane1 +3; mode 2: lane0 0x7FFF then +1s
  task automatic fill_mem(input int mode);
    for (int k = 0; k < NK; k++)
      for (int o = 0; o < NOUT; o++)
        case (mode)
          0:       mem[k*NOUT+o] = lanes(16'd1, 16'd1, 16'd1);
          1:       mem[k*NOUT+o] = lanes(16'hFFFB, 16'd3, 16'd0);
          default: mem[k*NOUT+o] = (k == 0) ? lanes(16'h7FFF, 16'd1, 16'd0)
                                            : lanes(16'd1, 16'd1, 16'd0);
        endcase
  endtask

  function automatic logic [DW-1:0] exp_data(input int mode);
    case (mode)
      0:       return lanes(16'd9, 16'd9, 16'd9);
      1:       return lanes(16'd0, 16'd27, 16'd0);
      default: return lanes(16'd0, 16'd9, 16'd0);
    endcase
  endfunction

  task automatic clear_queues();
    exp_raddr.delete();
    exp_waddr.delete();
    exp_wdata.delete();
    exp_done.delete();
  endtask

  task automatic start_run(input int mode);
    fill_mem(mode);
    for (int o = 0; o < NOUT; o++) begin
      for (int k = 0; k < NK; k++) exp_raddr.push_back(ABW'(k*NOUT + o));
      exp_waddr.push_back(ABW'(o));
      exp_wdata.push_back(exp_data(mode));
    end
    @(negedge clk); #1;
    start = 1'b1;
    exp_done.push_back(cyc + 193);
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", DW'(busy), 1);
  endtask

  task automatic wait_empty();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_raddr.size() == 0 && exp_waddr.size() == 0 && exp_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("run_timeout", 1, 0);
      clear_queues();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, DW'(busy), 0);
    check({tag, "_done"}, DW'(done), 0);
    check({tag, "_psum_ren"}, DW'(psum_ren), 0);
    check({tag, "_sfu_acc"}, DW'(sfu_acc), 0);
    check({tag, "_out_wen"}, DW'(out_wen), 0);
    check({tag, "_psum_addr"}, DW'(psum_addr), 0);
    check({tag, "_out_addr"}, DW'(out_addr), 0);
    check({tag, "_out_d"}, out_d, 0);
  endtask

  initial begin
    bit hit;
    reset = 1'b1;
    start = 1'b0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // All lanes +1: sums of 9, done 193 cycles after start
    start_run(0);
    wait_empty();

    // Negative lane clamps to 0, positive lane sums to 27
    start_run(1);
    wait_empty();

    // Overflowing lane wraps negative and is clamped
    start_run(2);
    wait_empty();

    // Start pulse during TAIL of o=3 is ignored
    start_run(0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (psum_ren && psum_addr == ABW'(8*NOUT + 3)) begin hit = 1'b1; break; end
    end
    check("tail_o3_reached", DW'(hit), 1);
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_empty();

    // Reset during READ of o=5 aborts the run silently
    start_run(0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (psum_ren && psum_addr == ABW'(5)) begin hit = 1'b1; break; end
    end
    check("read_o5_reached", DW'(hit), 1);
    #1 reset = 1'b1;
    clear_queues();
    @(negedge clk);
    check_quiet("abort");
    #1 reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_restart_busy", DW'(busy), 0);

    // Restart after abort yields a full run from o=0
    start_run(0);
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_sfu_ctrl.md
PSUM_SFU_CTRL -- requirements
Module: psum_sfu_ctrl

Interface
REQ-001 SHALL have parameter col, default 8, meaning the number of output-channel lanes.
REQ-002 SHALL have parameter psum_bw, default 16, meaning the bit width of each lane's partial sum.
REQ-003 SHALL have parameter num_k, default 9, meaning the number of kernel positions accumulated per output.
REQ-004 SHALL have parameter num_out, default 16, meaning the number of output pixels per run.
REQ-005 SHALL have parameter addr_bw, default 8, meaning the width of the memory address.
REQ-006 SHALL have port clk, input, 1 bit: the clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begins a run when sampled in IDLE.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a run.
REQ-011 SHALL have port psum_ren, output, 1 bit: psum memory read enable.
REQ-012 SHALL have port psum_addr, output, addr_bw bits: psum memory read address.
REQ-013 SHALL have port psum_q, input, col*psum_bw bits: psum memory read data, valid the cycle after psum_ren.
REQ-014 SHALL have port sfu_acc, output, 1 bit: accumulate enable to the col SFU lanes.
REQ-015 SHALL have port sfu_psum, output, col*psum_bw bits: packed psums to the SFU lanes, lane i at bits [i*psum_bw +: psum_bw].
REQ-016 SHALL have port sfu_out, input, col*psum_bw bits: packed post-ReLU SFU results.
REQ-017 SHALL have port out_wen, output, 1 bit: output memory write enable.
REQ-018 SHALL have port out_addr, output, addr_bw bits: output memory write address.
REQ-019 SHALL have port out_d, output, col*psum_bw bits: output memory write data.

Function
REQ-020 SHALL implement states IDLE, READ, TAIL, FLUSH, WRITE and DONE, with an output counter o (0..num_out-1) and a kernel counter k (0..num_k-1).
REQ-021 SHALL, in IDLE, move to READ with o=0 and k=0 when start=1, and otherwise stay in IDLE.
REQ-022 SHALL, in READ, drive psum_ren=1 and psum_addr=k*num_out+o, and increment k each cycle; after the cycle with k=num_k-1 it SHALL clear k and go to TAIL.
REQ-023 SHALL, in TAIL, drive psum_ren=0 and advance to FLUSH after one cycle.
REQ-024 SHALL, in FLUSH, advance to WRITE after one cycle; sfu_acc is 0 in this cycle so the SFU latches ReLU(sum) and clears.
REQ-025 SHALL, in WRITE, drive out_wen=1, out_addr=o and out_d=sfu_out; then go to DONE if o=num_out-1, otherwise increment o and go to READ.
REQ-026 SHALL, in DONE, drive done=1 for exactly one cycle and then go to IDLE.
REQ-027 SHALL register sfu_acc as (state==READ) delayed one cycle, so it is high exactly num_k cycles per output: READ cycles 1..num_k-1 plus TAIL.
REQ-028 SHALL drive sfu_psum combinationally from psum_q with no width change, sign or saturation handling.
REQ-029 SHALL hold psum_ren, out_wen and done at 0 outside the states that assert them, and hold psum_addr, out_addr and out_d at 0 when their enables are 0.
REQ-030 SHALL ignore start in every state other than IDLE, with no restart and no counter change.
REQ-031 SHALL take exactly num_k+3 cycles per output, giving done num_out*(num_k+3)+1 cycles after the cycle in which start is sampled.
REQ-032 SHALL keep sfu_acc at 0 in IDLE, WRITE and DONE, so the SFU accumulator is cleared before each output.
REQ-033 SHALL make the psum_addr computation addr_bw wide; the configuration SHALL satisfy num_k*num_out <= 2^addr_bw.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, enter IDLE, clear o and k, and drive busy, done, psum_ren, sfu_acc and out_wen to 0 and all address and data outputs to 0.
REQ-035 SHALL, when reset occurs mid-run, abort the run with no further reads or writes and no done pulse; the next start SHALL begin again from o=0.

Verification
REQ-036 SHALL pass this scenario: every psum_q lane=+1 with a behavioural SFU model -> 16 writes at addresses 0..15, each lane=9; done at cycle 193 after start.
REQ-037 SHALL pass this scenario: lane0 psums all -5 and lane1 all +3 -> every write has lane0=0 and lane1=27.
REQ-038 SHALL pass this scenario: run started, monitor output o=2 -> psum_addr sequence 2,18,34,...,130 on 9 consecutive psum_ren cycles.
REQ-039 SHALL pass this scenario: reset asserted during READ of o=5 -> next cycle busy=0, psum_ren=0, out_wen=0, no done; a restart then yields all 16 writes.
REQ-040 SHALL pass this scenario: start pulsed during TAIL of o=3 -> no effect; write sequence and done timing are unchanged.
REQ-041 SHALL pass this scenario: lane psums 0x7FFF followed by +1s -> the sum wraps negative and the written lane=0, matching the SFU wrap semantics.
